spi_frame_receiver: RTL and testbench



---
 rtl/spi_frame_receiver.sv | 168 ++++++++++++++++
 tb/tb_spi_frame_receiver.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_receiver.sv
// Purpose: SPI slave receiver for the DAC link; oversamples SS_n/SCLK/SDI in the clk domain.
// Latency: SYNC_STAGES+1 clk from a pin edge to its detection; valid/err in the following (DONE) cycle.
// Backpressure: none; out is held until the next accepted frame, and valid/err are single-cycle strobes.
//
// Ports:
//   clk, reset_n   system clock (rising edge) and asynchronous active-low reset
//   SS_n, SCLK     slave select and serial clock from the master (async to clk)
//   SDI            serial data from the master (async to clk), MSB first,
//                  sampled on SCLK falling edges
//   out [BITS-1:0] last accepted word
//   valid          one-cycle strobe: out updated this cycle
//   err            one-cycle strobe: frame rejected (frame check builds only)
//   busy           high from frame start through the DONE cycle
//
// Build option: define SPI_RX_FRAME_CHECK_EN to reject frames whose bit count
// is not exactly BITS. When it is undefined, every frame is accepted and err stays 0.

module spi_frame_receiver #(
  parameter int BITS        = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            SS_n,
  input  logic            SCLK,
  input  logic            SDI,
  output logic [BITS-1:0] out,
  output logic            valid,
  output logic            err,
  output logic            busy
);

  localparam int            CW       = $clog2(BITS + 2);
  localparam logic [CW-1:0] CNT_MAX  = CW'(BITS + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(BITS);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [SYNC_STAGES-1:0] ss_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] sdi_sync;
  logic                   ss_d;
  logic                   sclk_d;
  logic [SYNC_STAGES-1:0] warm;
  logic                   armed;

  logic [1:0]      state;
  logic [BITS-1:0] shift;
  logic [CW-1:0]   cnt;
  logic            err_q;

  logic            ss_s;
  logic            sclk_s;
  logic            sdi_s;
  logic            sclk_fall;
  logic            ss_rise;
  logic [BITS-1:0] shift_nxt;
  logic [CW-1:0]   cnt_nxt;
  logic            frame_ok;

  // Synchronizers plus one edge-detect register for SS_n and SCLK.
  // SDI is taken from the same depth as SCLK so it is sampled at the fall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ss_sync   <= '1;
      sclk_sync <= '1;
      sdi_sync  <= '0;
      ss_d      <= 1'b1;
      sclk_d    <= 1'b1;
    end else begin
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_n};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], SDI};
      ss_d      <= ss_sync[SYNC_STAGES-1];
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
    end
  end

  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync[SYNC_STAGES-1];
  assign sclk_fall = sclk_d & ~sclk_s;
  assign ss_rise   = ss_s & ~ss_d;

  // The SS_n synchronizer resets to "deselected", so a master that is
  // mid-frame when reset releases would look like a fresh frame start.
  // Only arm once a real (pin-derived) high level on SS_n has been seen.
  // This discards the partial frame and resumes at the next SS_n fall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      warm  <= '0;
      armed <= 1'b0;
    end else begin
      warm <= {warm[SYNC_STAGES-2:0], 1'b1};
      if (warm[SYNC_STAGES-1] && ss_s) begin
        armed <= 1'b1;
      end
    end
  end

  // Next shift/count values include a bit whose SCLK fall coincides with
  // the SS_n rise, so the frame is judged on the complete bit set.
  always_comb begin
    shift_nxt = shift;
    cnt_nxt   = cnt;
    if (sclk_fall) begin
      shift_nxt = {shift[BITS-2:0], sdi_s};
      cnt_nxt   = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    end
  end

`ifdef SPI_RX_FRAME_CHECK_EN
  assign frame_ok = (cnt_nxt == CNT_FULL);
`else
  assign frame_ok = 1'b1;
`endif

  // The frame is evaluated on the SHIFT->DONE edge so that valid/err and
  // out are visible during the DONE cycle itself.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      shift <= '0;
      cnt   <= '0;
      out   <= '0;
      valid <= 1'b0;
      err_q <= 1'b0;
    end else begin
      valid <= 1'b0;
      err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (armed && !ss_s) begin
            state <= ST_SHIFT;
            shift <= '0;
            cnt   <= '0;
          end
        end
        ST_SHIFT: begin
          shift <= shift_nxt;
          cnt   <= cnt_nxt;
          if (ss_rise) begin
            state <= ST_DONE;
            if (frame_ok) begin
              out   <= shift_nxt;
              valid <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Without the frame check, frame_ok is constant 1 and err_q never sets.
  assign err  = err_q;
  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Purpose: directed bench for spi_frame_receiver (BITS=16, SYNC_STAGES=2).
// Latency: checks strobe timing relative to SS_n pin edges at clk resolution.
// Backpressure: none; stimulus is driven 1 time unit after each clk falling edge.

module tb_spi_frame_receiver;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        SS_n;
  logic        SCLK;
  logic        SDI;
  logic [15:0] out;
  logic        valid;
  logic        err;
  logic        busy;

  int n_vec = 0;
  int n_bad = 0;

  // strobe monitor
  int          vcnt = 0;
  int          ecnt = 0;
  int          both = 0;
  logic [15:0] vq[$];

  always #5 clk = ~clk;

  spi_frame_receiver #(.BITS(16), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .SDI     (SDI),
    .out     (out),
    .valid   (valid),
    .err     (err),
    .busy    (busy)
  );

  always @(negedge clk) begin
    if (valid) begin
      vcnt++;
      vq.push_back(out);
    end
    if (err) ecnt++;
    if (valid && err) both++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Clocks data[hi] down to data[lo]: SDI changes with SCLK rising (3 clk
  // high), sampled at SCLK falling (2 clk low). Ends with SCLK high.
  task automatic shift_bits(input int hi, input int lo, input logic [31:0] data, input bit coinc);
    for (int i = hi; i >= lo; i--) begin
      SCLK = 1'b1;
      SDI  = data[i];
      tick(3);
      SCLK = 1'b0;
      if (coinc && i == lo) SS_n = 1'b1;
      tick(2);
    end
    SCLK = 1'b1;
  endtask

  task automatic send_frame(input int nbits, input logic [31:0] data, input bit coinc);
    SS_n = 1'b0;
    tick(3);
    shift_bits(nbits - 1, 0, data, coinc);
    if (!coinc) begin
      tick(2);
      SS_n = 1'b1;
    end
  endtask

  int v0, e0;

  initial begin
    reset_n = 1'b0;
    SS_n    = 1'b1;
    SCLK    = 1'b1;
    SDI     = 1'b0;
    tick(2);
    check_val("rst_out",   32'(out), 32'h0);
    check_val("rst_valid", 32'(valid), 32'h0);
    check_val("rst_err",   32'(err), 32'h0);
    check_val("rst_busy",  32'(busy), 32'h0);
    reset_n = 1'b1;
    tick(4);

    // Frame 0xA5C3 with exact strobe/busy timing
    SS_n = 1'b0;
    tick(2);
    check_val("busy_before_detect", 32'(busy), 32'h0);
    tick(1);
    check_val("busy_after_detect", 32'(busy), 32'h1);
    shift_bits(15, 0, 32'hA5C3, 1'b0);
    tick(2);
    SS_n = 1'b1;
    tick(2);
    check_val("valid_early", 32'(valid), 32'h0);
    tick(1);
    check_val("valid_done",  32'(valid), 32'h1);
    check_val("out_a5c3",    32'(out), 32'hA5C3);
    check_val("err_a5c3",    32'(err), 32'h0);
    check_val("busy_done",   32'(busy), 32'h1);
    tick(1);
    check_val("valid_width", 32'(valid), 32'h0);
    check_val("busy_idle",   32'(busy), 32'h0);
    tick(4);
    check_val("a5c3_pulses", 32'(vcnt), 32'd1);

    // Back-to-back frames, SS_n high for 2 clk
    vq.delete();
    v0 = vcnt;
    send_frame(16, 32'h0001, 1'b0);
    tick(2);
    send_frame(16, 32'hFFFF, 1'b0);
    tick(8);
    check_val("b2b_pulses", 32'(vcnt - v0), 32'd2);
    if (vq.size() == 2) begin
      check_val("b2b_first",  32'(vq[0]), 32'h0001);
      check_val("b2b_second", 32'(vq[1]), 32'hFFFF);
    end else begin
      check_val("b2b_queue", 32'(vq.size()), 32'd2);
    end

    // Short frame: 15 bits of ones
    v0 = vcnt;
    e0 = ecnt;
    send_frame(15, 32'h7FFF, 1'b0);
    tick(8);
`ifdef SPI_RX_FRAME_CHECK_EN
    check_val("short_err",   32'(ecnt - e0), 32'd1);
    check_val("short_valid", 32'(vcnt - v0), 32'd0);
    check_val("short_out",   32'(out), 32'hFFFF);
`else
    check_val("short_err",   32'(ecnt - e0), 32'd0);
    check_val("short_valid", 32'(vcnt - v0), 32'd1);
    check_val("short_out",   32'(out), 32'h7FFF);
`endif

    // Long frame: 0x1234 then an extra 0 bit
    v0 = vcnt;
    e0 = ecnt;
    send_frame(17, 32'h02468, 1'b0);
    tick(8);
`ifdef SPI_RX_FRAME_CHECK_EN
    check_val("long_err",   32'(ecnt - e0), 32'd1);
    check_val("long_valid", 32'(vcnt - v0), 32'd0);
    check_val("long_out",   32'(out), 32'hFFFF);
`else
    check_val("long_err",   32'(ecnt - e0), 32'd0);
    check_val("long_valid", 32'(vcnt - v0), 32'd1);
    check_val("long_out",   32'(out), 32'h2468);
`endif

    // Last SCLK fall coincident with SS_n rise
    v0 = vcnt;
    send_frame(16, 32'h3C96, 1'b1);
    tick(8);
    check_val("coinc_valid", 32'(vcnt - v0), 32'd1);
    check_val("coinc_out",   32'(out), 32'h3C96);

    // Reset after 8 bits, remainder of the frame must be discarded
    SS_n = 1'b0;
    tick(3);
    shift_bits(15, 8, 32'hC3C3, 1'b0);
    tick(1);
    reset_n = 1'b0;
    #1;
    check_val("midrst_out",  32'(out), 32'h0);
    check_val("midrst_busy", 32'(busy), 32'h0);
    tick(2);
    reset_n = 1'b1;
    v0 = vcnt;
    e0 = ecnt;
    tick(2);
    shift_bits(7, 0, 32'hC3C3, 1'b0);
    tick(2);
    SS_n = 1'b1;
    tick(8);
    check_val("midrst_no_valid", 32'(vcnt - v0), 32'd0);
    check_val("midrst_no_err",   32'(ecnt - e0), 32'd0);
    check_val("midrst_out_hold", 32'(out), 32'h0);
    send_frame(16, 32'h5A5A, 1'b0);
    tick(8);
    check_val("post_rst_valid", 32'(vcnt - v0), 32'd1);
    check_val("post_rst_out",   32'(out), 32'h5A5A);

    check_val("never_both", 32'(both), 32'd0);
`ifndef SPI_RX_FRAME_CHECK_EN
    check_val("err_never", 32'(ecnt), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
